// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: captures fetch results, pre-decodes the one-hot
// immediate select for imm_gen, and supports stall (hold) and flush (bubble).
module if_id_stage_reg #(
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_if_valid,
  input  logic [PC_W-1:0] i_if_pc,
  input  logic [31:0]     i_if_inst,
  input  logic            i_if_pred_taken,
  input  logic [PC_W-1:0] i_if_pred_target,
  output logic            o_id_valid,
  output logic [PC_W-1:0] o_id_pc,
  output logic [31:0]     o_id_inst,
  output logic [4:0]      o_id_imm_sel,
  output logic            o_id_pred_taken,
  output logic [PC_W-1:0] o_id_pred_target,
  output logic            o_id_illegal
);

  logic [4:0] dec_imm_sel;
  logic       dec_illegal;

  // Opcode decode happens ahead of the register so ID sees a ready one-hot select.
  always_comb begin
    dec_imm_sel = 5'b00000;
    dec_illegal = 1'b0;
    case (i_if_inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: dec_imm_sel = 5'b00001;
      7'b0001111, 7'b1110011:             dec_imm_sel = 5'b00001;
      7'b0100011:                         dec_imm_sel = 5'b00010;
      7'b1100011:                         dec_imm_sel = 5'b00100;
      7'b1101111:                         dec_imm_sel = 5'b01000;
      7'b0110111, 7'b0010111:             dec_imm_sel = 5'b10000;
      7'b0110011:                         dec_imm_sel = 5'b00000;
      default:                            dec_illegal = 1'b1;
    endcase
  end

  // Flush beats stall so a mispredict squashes even a held instruction.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush || (!i_stall && !i_if_valid)) begin
      o_id_valid       <= 1'b0;
      o_id_pc          <= '0;
      o_id_inst        <= NOP_INST;
      o_id_imm_sel     <= 5'b00001;
      o_id_pred_taken  <= 1'b0;
      o_id_pred_target <= '0;
      o_id_illegal     <= 1'b0;
    end else if (!i_stall) begin
      o_id_valid       <= 1'b1;
      o_id_pc          <= i_if_pc;
      o_id_inst        <= i_if_inst;
      o_id_imm_sel     <= dec_imm_sel;
      o_id_pred_taken  <= i_if_pred_taken;
      o_id_pred_target <= i_if_pred_target;
      o_id_illegal     <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Scoreboard bench for if_id_stage_reg: stimulus pushes model predictions,
// a monitor pops and compares one entry per clock edge.
module tb_if_id_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  imm_sel;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        illegal;
  } id_view_t;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, if_valid, if_pred_taken;
  logic [31:0] if_pc, if_inst, if_pred_target;
  logic        id_valid, id_pred_taken, id_illegal;
  logic [31:0] id_pc, id_inst, id_pred_target;
  logic [4:0]  id_imm_sel;

  id_view_t expect_q[$];
  id_view_t model_state;
  int       total = 0;
  int       bad   = 0;
  bit       stim_done = 0;

  if_id_stage_reg #(.PC_W(32), .NOP_INST(32'h0000_0013)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
    .i_if_valid(if_valid), .i_if_pc(if_pc), .i_if_inst(if_inst),
    .i_if_pred_taken(if_pred_taken), .i_if_pred_target(if_pred_target),
    .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_inst(id_inst),
    .o_id_imm_sel(id_imm_sel), .o_id_pred_taken(id_pred_taken),
    .o_id_pred_target(id_pred_target), .o_id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  function automatic id_view_t bubble();
    id_view_t b;
    b = '{valid: 1'b0, pc: 32'h0, inst: 32'h13, imm_sel: 5'b00001,
          pred_taken: 1'b0, pred_target: 32'h0, illegal: 1'b0};
    return b;
  endfunction

  // Immediate format index: 0=I 1=S 2=B 3=UJ 4=U, -1 = no immediate, -2 = illegal.
  function automatic int imm_kind(input logic [6:0] op);
    case (op)
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: return 0;
      7'h23: return 1;
      7'h63: return 2;
      7'h6F: return 3;
      7'h37, 7'h17: return 4;
      7'h33: return -1;
      default: return -2;
    endcase
  endfunction

  task automatic applyStimulus(input logic r, input logic st, input logic fl,
                               input logic v, input logic [31:0] pc,
                               input logic [31:0] inst, input logic pt,
                               input logic [31:0] ptg);
    int k;
    @(negedge clk);
    rst_n = r; stall = st; flush = fl; if_valid = v; if_pc = pc;
    if_inst = inst; if_pred_taken = pt; if_pred_target = ptg;
    if (!r || fl || (!st && !v)) begin
      model_state = bubble();
    end else if (!st) begin
      k = imm_kind(inst[6:0]);
      model_state.valid       = 1'b1;
      model_state.pc          = pc;
      model_state.inst        = inst;
      model_state.imm_sel     = (k >= 0) ? 5'(1 << k) : 5'b00000;
      model_state.pred_taken  = pt;
      model_state.pred_target = ptg;
      model_state.illegal     = (k == -2);
    end
    expect_q.push_back(model_state);
  endtask

  task automatic checkOutput(input id_view_t exp_v);
    id_view_t act;
    act = '{valid: id_valid, pc: id_pc, inst: id_inst, imm_sel: id_imm_sel,
            pred_taken: id_pred_taken, pred_target: id_pred_target,
            illegal: id_illegal};
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("[TB] FAIL id_regs t=%0t act v=%b pc=%h inst=%h sel=%b pt=%b ptg=%h ill=%b exp v=%b pc=%h inst=%h sel=%b pt=%b ptg=%h ill=%b",
               $time, act.valid, act.pc, act.inst, act.imm_sel, act.pred_taken,
               act.pred_target, act.illegal, exp_v.valid, exp_v.pc, exp_v.inst,
               exp_v.imm_sel, exp_v.pred_taken, exp_v.pred_target, exp_v.illegal);
    end
    total++;
    if (!$onehot0(id_imm_sel)) begin
      bad++;
      $display("[TB] FAIL imm_sel_onehot act=%b exp=at most one bit set", id_imm_sel);
    end
  endtask

  // Monitor: the register updates every edge, so each edge retires one prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expect_q.size() > 0) checkOutput(expect_q.pop_front());
    end
  end

  logic [6:0] opcodes [12] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                               7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F};

  initial begin
    logic [31:0] ri;
    model_state = bubble();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; if_valid = 1'b0;
    if_pc = '0; if_inst = '0; if_pred_taken = 1'b0; if_pred_target = '0;

    // Reset with random inputs on the other pins
    repeat (2) applyStimulus(1'b0, $urandom_range(0, 1), $urandom_range(0, 1),
                             1'b1, $urandom, $urandom, 1'b1, $urandom);
    // Load addi sp,sp,-32
    applyStimulus(1, 0, 0, 1, 32'h100, 32'hFE010113, 0, 32'h104);
    // Decode sweep
    applyStimulus(1, 0, 0, 1, 32'h104, 32'h00A12223, 0, 32'h108);
    applyStimulus(1, 0, 0, 1, 32'h108, 32'hFE000EE3, 1, 32'h0F0);
    applyStimulus(1, 0, 0, 1, 32'h10C, 32'h008000EF, 1, 32'h114);
    applyStimulus(1, 0, 0, 1, 32'h110, 32'h123452B7, 0, 32'h114);
    applyStimulus(1, 0, 0, 1, 32'h114, 32'h00B50533, 0, 32'h118);
    // Stall holds the 0x100 contents, then 0x108 loads when it drops
    applyStimulus(1, 0, 0, 1, 32'h100, 32'hFE010113, 0, 32'h104);
    applyStimulus(1, 1, 0, 1, 32'h104, 32'h00A12223, 0, 32'h108);
    applyStimulus(1, 1, 0, 1, 32'h108, 32'hFE000EE3, 1, 32'h200);
    applyStimulus(1, 1, 0, 1, 32'h108, 32'hFE000EE3, 1, 32'h200);
    applyStimulus(1, 0, 0, 1, 32'h108, 32'hFE000EE3, 1, 32'h200);
    // Flush together with stall
    applyStimulus(1, 0, 0, 1, 32'h10C, 32'h008000EF, 1, 32'h114);
    applyStimulus(1, 1, 1, 1, 32'h110, 32'h008000EF, 1, 32'h118);
    // Illegal opcode, then idle
    applyStimulus(1, 0, 0, 1, 32'h120, 32'h0000007F, 0, 32'h124);
    applyStimulus(1, 0, 0, 0, 32'h124, 32'h0000007F, 0, 32'h128);
    // Reset released mid-stall
    applyStimulus(1, 0, 0, 1, 32'h130, 32'h00A12223, 1, 32'h134);
    applyStimulus(0, 1, 0, 1, 32'h134, 32'h00A12223, 1, 32'h138);
    applyStimulus(1, 1, 0, 1, 32'h138, 32'h00A12223, 1, 32'h13C);
    applyStimulus(1, 0, 0, 1, 32'h13C, 32'h123452B7, 0, 32'h140);

    for (int i = 0; i < 400; i++) begin
      ri = $urandom;
      ri[6:0] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : opcodes[$urandom_range(0, 11)];
      applyStimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0),
                    $urandom, ri, 1'($urandom), $urandom);
    end
    stim_done = 1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (!stim_done || expect_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain act_pending=%0d exp_pending=0 stim_done=%0b", expect_q.size(), stim_done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
